// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: serializes a captured 4-character ASCII word (MSB character
// first, optionally followed by CR/LF) as back-to-back 8N1 UART frames.
module ascii_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          APPEND_CRLF  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ascii_in,
    input  logic        ascii_valid,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int unsigned BaudW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
    // Index of the final byte of a message: 4 digits, plus CR and LF if enabled
    localparam logic [2:0]  LastIdx = APPEND_CRLF ? 3'd5 : 3'd3;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       buf_q, buf_d;
    // Holds the bits of the current byte not yet placed on the line
    logic [6:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              valid_q;

    logic              rise;
    logic              bit_end;
    logic [7:0]        cur_byte;

    assign rise    = ascii_valid & ~valid_q;
    assign bit_end = (baud_q == BaudMax);

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

    // Select the byte of the message addressed by byte_idx
    always_comb begin
        unique case (byte_idx_q)
            3'd0:    cur_byte = buf_q[31:24];
            3'd1:    cur_byte = buf_q[23:16];
            3'd2:    cur_byte = buf_q[15:8];
            3'd3:    cur_byte = buf_q[7:0];
            3'd4:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Next-state, counters and registered-output next values
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (rise) begin
                    buf_d      = ascii_in;
                    byte_idx_d = 3'd0;
                    baud_d     = '0;
                    busy_d     = 1'b1;
                    tx_d       = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    shift_d   = cur_byte[7:1];
                    tx_d      = cur_byte[0];
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[6:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_idx_q < LastIdx) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        tx_d       = 1'b0;
                        state_d    = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase

        // A new word arriving mid-message is dropped, not queued
        if (rise && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            buf_q      <= 32'd0;
            shift_q    <= 7'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            valid_q    <= ascii_valid;
        end
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Testbench for ascii_uart_tx: two instances (with and without CR/LF) checked
// cycle by cycle against an arithmetic model of the expected UART line.
module tb_ascii_uart_tx;

    localparam int C = 4;

    logic        clk;
    logic        rst;
    logic [31:0] a_in1, a_in0;
    logic        v1, v0;
    logic        tx1, busy1, done1, ovr1;
    logic        tx0, busy0, done0, ovr0;

    int n_checks;
    int n_fail;

    logic r_tx1 [0:1023];
    logic r_busy1 [0:1023];
    logic r_done1 [0:1023];
    logic r_ovr1 [0:1023];
    logic r_tx0 [0:1023];
    logic r_busy0 [0:1023];
    logic r_done0 [0:1023];
    logic r_ovr0 [0:1023];

    ascii_uart_tx #(.CLKS_PER_BIT(C), .APPEND_CRLF(1'b1)) dut (
        .clk(clk), .rst(rst), .ascii_in(a_in1), .ascii_valid(v1),
        .tx(tx1), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    ascii_uart_tx #(.CLKS_PER_BIT(C), .APPEND_CRLF(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .ascii_in(a_in0), .ascii_valid(v0),
        .tx(tx0), .busy(busy0), .done(done0), .overrun(ovr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte i of a message built from word w (digits MSB first, then CR, LF)
    function automatic logic [7:0] msg_byte(input logic [31:0] w, input int i);
        case (i)
            0: return w[31:24];
            1: return w[23:16];
            2: return w[15:8];
            3: return w[7:0];
            4: return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Expected line level k cycles after the start bit of a message begins
    function automatic logic model_tx(input logic [31:0] w, input int nbytes, input int k);
        int f;
        int b;
        logic [7:0] by;
        if (k < 0 || k >= nbytes * 10 * C) return 1'b1;
        f  = k / (10 * C);
        b  = (k % (10 * C)) / C;
        by = msg_byte(w, f);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    task automatic sample(input int k);
        r_tx1[k] = tx1; r_busy1[k] = busy1; r_done1[k] = done1; r_ovr1[k] = ovr1;
        r_tx0[k] = tx0; r_busy0[k] = busy0; r_done0[k] = done0; r_ovr0[k] = ovr0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx1, busy1, done1, ovr1} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_crlf: got tx/busy/done/ovr=%b want 1000",
                     {tx1, busy1, done1, ovr1});
        end
        n_checks++;
        if ({tx0, busy0, done0, ovr0} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_nocrlf: got tx/busy/done/ovr=%b want 1000",
                     {tx0, busy0, done0, ovr0});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx1, busy1, tx0, busy0} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want 1010", {tx1, busy1, tx0, busy0});
        end
    endtask

    task automatic test_basic;
        logic [31:0] w;
        int bad;
        int first;
        logic [47:0] dec;
        w = 32'h31323334;
        @(negedge clk);
        a_in1 = w; v1 = 1'b1;
        for (int k = 0; k < 60 * C + 12; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 3) v1 = 1'b0;
        end
        bad = 0; first = -1;
        for (int k = 0; k < 60 * C + 12; k++) begin
            if (r_tx1[k] !== model_tx(w, 6, k) || r_busy1[k] !== (k < 60 * C) ||
                r_done1[k] !== (k == 60 * C) || r_ovr1[k] !== 1'b0) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL basic_wave: %0d bad cycles, first at %0d, want 0", bad, first);
        end
        n_checks++;
        if (r_done1[60 * C] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done_time: done at 240 = %b want 1", r_done1[60 * C]);
        end
        // Mid-bit sampling receiver
        dec = '0;
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < 8; b++) begin
                dec[(5 - f) * 8 + b] = r_tx1[f * 10 * C + (b + 1) * C + C / 2];
            end
        end
        n_checks++;
        if (dec !== 48'h31323334_0D0A) begin
            n_fail++;
            $display("FAIL basic_decode: got %h want 313233340d0a", dec);
        end
    endtask

    task automatic test_random;
        logic [31:0] w1, w0;
        int bad1;
        int bad0;
        for (int it = 0; it < 4; it++) begin
            w1 = $urandom; w0 = $urandom;
            @(negedge clk);
            a_in1 = w1; v1 = 1'b1;
            a_in0 = w0; v0 = 1'b1;
            for (int k = 0; k < 60 * C + 6; k++) begin
                @(negedge clk);
                sample(k);
                if (k == 2) begin
                    v1 = 1'b0; v0 = 1'b0;
                    a_in1 = $urandom; a_in0 = $urandom;
                end
            end
            bad1 = 0; bad0 = 0;
            for (int k = 0; k < 60 * C + 6; k++) begin
                if (r_tx1[k] !== model_tx(w1, 6, k) || r_busy1[k] !== (k < 60 * C) ||
                    r_done1[k] !== (k == 60 * C)) bad1++;
                if (r_tx0[k] !== model_tx(w0, 4, k) || r_busy0[k] !== (k < 40 * C) ||
                    r_done0[k] !== (k == 40 * C)) bad0++;
            end
            n_checks++;
            if (bad1 !== 0) begin
                n_fail++;
                $display("FAIL random_crlf word=%h: %0d bad cycles want 0", w1, bad1);
            end
            n_checks++;
            if (bad0 !== 0) begin
                n_fail++;
                $display("FAIL random_nocrlf word=%h: %0d bad cycles want 0", w0, bad0);
            end
        end
    endtask

    task automatic test_no_crlf;
        logic [31:0] w;
        int busy_cnt;
        int done_cnt;
        int bad;
        logic [31:0] dec;
        w = 32'h30303939;
        @(negedge clk);
        a_in0 = w; v0 = 1'b1;
        for (int k = 0; k < 60 * C; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 4) v0 = 1'b0;
        end
        busy_cnt = 0; done_cnt = 0; bad = 0;
        for (int k = 0; k < 60 * C; k++) begin
            if (r_busy0[k] === 1'b1) busy_cnt++;
            if (r_done0[k] === 1'b1) done_cnt++;
            if (r_tx0[k] !== model_tx(w, 4, k)) bad++;
        end
        dec = '0;
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 8; b++) begin
                dec[(3 - f) * 8 + b] = r_tx0[f * 10 * C + (b + 1) * C + C / 2];
            end
        end
        n_checks++;
        if (busy_cnt !== 40 * C) begin
            n_fail++;
            $display("FAIL nocrlf_busy_len: got %0d want %0d", busy_cnt, 40 * C);
        end
        n_checks++;
        if (done_cnt !== 1 || r_done0[40 * C] !== 1'b1) begin
            n_fail++;
            $display("FAIL nocrlf_done: count %0d at160=%b want 1/1", done_cnt, r_done0[40 * C]);
        end
        n_checks++;
        if (bad !== 0 || dec !== 32'h30303939) begin
            n_fail++;
            $display("FAIL nocrlf_frames: bad=%0d decoded=%h want 0/30303939", bad, dec);
        end
    endtask

    task automatic test_overrun;
        logic [31:0] w;
        int bad;
        int ovr_cnt;
        w = $urandom;
        @(negedge clk);
        a_in1 = w; v1 = 1'b1;
        for (int k = 0; k < 60 * C + 3 * 10 * C; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 5) v1 = 1'b0;
            if (k == 50) begin
                v1 = 1'b1; a_in1 = 32'h35353535;
            end
        end
        v1 = 1'b0;
        bad = 0; ovr_cnt = 0;
        for (int k = 0; k < 60 * C + 3 * 10 * C; k++) begin
            if (r_ovr1[k] === 1'b1) ovr_cnt++;
            if (r_tx1[k] !== model_tx(w, 6, k) || r_busy1[k] !== (k < 60 * C) ||
                r_done1[k] !== (k == 60 * C)) bad++;
        end
        n_checks++;
        if (ovr_cnt !== 1 || r_ovr1[51] !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_pulse: count %0d at51=%b want 1/1", ovr_cnt, r_ovr1[51]);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL overrun_msg_intact: %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_held;
        logic [31:0] w;
        logic [31:0] w2;
        int bad;
        w = $urandom; w2 = $urandom;
        @(negedge clk);
        a_in1 = w; v1 = 1'b1;
        for (int k = 0; k < 2 * 60 * C + 20; k++) begin
            @(negedge clk);
            sample(k);
        end
        bad = 0;
        for (int k = 0; k < 2 * 60 * C + 20; k++) begin
            if (r_tx1[k] !== model_tx(w, 6, k) || r_done1[k] !== (k == 60 * C) ||
                r_ovr1[k] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL held_single_msg: %0d bad cycles want 0", bad);
        end
        @(negedge clk);
        v1 = 1'b0;
        @(negedge clk);
        a_in1 = w2; v1 = 1'b1;
        for (int k = 0; k < 60 * C + 4; k++) begin
            @(negedge clk);
            sample(k);
        end
        v1 = 1'b0;
        bad = 0;
        for (int k = 0; k < 60 * C + 4; k++) begin
            if (r_tx1[k] !== model_tx(w2, 6, k) || r_done1[k] !== (k == 60 * C)) bad++;
        end
        n_checks++;
        if (bad !== 0 || r_tx1[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL held_second_msg: %0d bad cycles, tx0=%b want 0/0", bad, r_tx1[0]);
        end
    endtask

    task automatic test_midreset;
        int bad;
        @(negedge clk);
        a_in1 = $urandom; v1 = 1'b1;
        // Third byte's frame starts at 80; offset 12 is inside its data bits
        for (int k = 0; k <= 2 * 10 * C + 12; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 3) v1 = 1'b0;
        end
        n_checks++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre_busy: got %b want 1", busy1);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({tx1, busy1, done1, ovr1} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midreset_async: got tx/busy/done/ovr=%b want 1000",
                     {tx1, busy1, done1, ovr1});
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_stays_idle: %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w1;
        logic [31:0] w2;
        int bad;
        int last;
        logic exp_tx;
        w1 = $urandom; w2 = $urandom;
        last = 60 * C + 1 + 60 * C + 4;
        @(negedge clk);
        a_in1 = w1; v1 = 1'b1;
        for (int k = 0; k < last; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 3) v1 = 1'b0;
            if (k == 60 * C) begin
                a_in1 = w2; v1 = 1'b1;
            end
            if (k == 60 * C + 4) v1 = 1'b0;
        end
        n_checks++;
        if (r_done1[60 * C] !== 1'b1 || r_tx1[60 * C + 1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%b next_tx=%b want 1/0",
                     r_done1[60 * C], r_tx1[60 * C + 1]);
        end
        bad = 0;
        for (int k = 0; k < last; k++) begin
            exp_tx = (k <= 60 * C) ? model_tx(w1, 6, k) : model_tx(w2, 6, k - 60 * C - 1);
            if (r_tx1[k] !== exp_tx || r_ovr1[k] !== 1'b0 ||
                r_busy1[k] !== (k < 60 * C || (k > 60 * C && k <= 120 * C)) ||
                r_done1[k] !== (k == 60 * C || k == 120 * C + 1)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_wave: %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        v1    = 1'b0;
        v0    = 1'b0;
        a_in1 = 32'd0;
        a_in0 = 32'd0;
        test_reset();
        test_basic();
        test_random();
        test_no_crlf();
        test_overrun();
        test_held();
        test_midreset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
